// File: rtl/hamming_pkg.sv
// Hamming (7,4) constants and pure encode/syndrome/correct functions shared by
// the encode and decode paths. Codeword index i holds Hamming position i+1.
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CODE_W = 7;
    localparam int SYN_W  = 3;

    typedef struct packed {
        logic [SYN_W-1:0]  syn;
        logic              err;
        logic [DATA_W-1:0] data;
    } dec_res_t;

    function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    function automatic logic [SYN_W-1:0] hamming_syndrome(input logic [CODE_W-1:0] c);
        logic [SYN_W-1:0] s;
        s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
        s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
        s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
        return s;
    endfunction

    // Pure SEC: a double error lands on a wrong position and is miscorrected.
    function automatic logic [DATA_W-1:0] hamming_correct(input logic [CODE_W-1:0] c,
                                                         input logic [SYN_W-1:0]  s);
        logic [CODE_W-1:0] fixed;
        fixed = c;
        if (s != '0)
            fixed = c ^ (CODE_W'(1) << (s - SYN_W'(1)));
        return {fixed[6], fixed[5], fixed[4], fixed[2]};
    endfunction

endpackage

// File: rtl/hamming_dec_stage.sv
// Decode stage: combinational syndrome/correction/extraction and its result
// register. err_hit flags an accepted decode with a nonzero syndrome.
module hamming_dec_stage
    import hamming_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [CODE_W-1:0] codeword_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [SYN_W-1:0]  syndrome_o,
    output logic              err_o,
    output logic              err_hit
);

    logic [1:0] vld_pipe;
    dec_res_t   res_d, res_q;

    assign vld_pipe[0] = valid_i;

    always_comb begin
        res_d      = '0;
        res_d.syn  = hamming_syndrome(codeword_i);
        res_d.err  = (res_d.syn != '0);
        res_d.data = hamming_correct(codeword_i, res_d.syn);
    end

    assign err_hit = valid_i & res_d.err;

    // Result fields hold across idle cycles; only the valid bit drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            res_q       <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (valid_i)
                res_q <= res_d;
        end
    end

    assign valid_o    = vld_pipe[1];
    assign data_o     = res_q.data;
    assign syndrome_o = res_q.syn;
    assign err_o      = res_q.err;

endmodule

// File: rtl/hamming_codec.sv
// Registered Hamming (7,4) SEC codec: independent 1-cycle encode and decode
// paths plus a saturating count of corrected words.
module hamming_codec
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_valid_i,
    input  logic [DATA_W-1:0] enc_data_i,
    output logic              enc_valid_o,
    output logic [CODE_W-1:0] enc_codeword_o,
    input  logic              dec_valid_i,
    input  logic [CODE_W-1:0] dec_codeword_i,
    output logic              dec_valid_o,
    output logic [DATA_W-1:0] dec_data_o,
    output logic [SYN_W-1:0]  dec_syndrome_o,
    output logic              dec_err_o,
    input  logic              err_count_clr_i,
    output logic [CNT_W-1:0]  err_count_o
);

    logic err_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_valid_o    <= 1'b0;
            enc_codeword_o <= '0;
        end else begin
            enc_valid_o <= enc_valid_i;
            if (enc_valid_i)
                enc_codeword_o <= hamming_encode(enc_data_i);
        end
    end

    hamming_dec_stage u_dec (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (dec_valid_i),
        .codeword_i (dec_codeword_i),
        .valid_o    (dec_valid_o),
        .data_o     (dec_data_o),
        .syndrome_o (dec_syndrome_o),
        .err_o      (dec_err_o),
        .err_hit    (err_hit)
    );

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_count_o <= '0;
        else if (err_count_clr_i)
            err_count_o <= '0;
        else if (err_hit && (err_count_o != {CNT_W{1'b1}}))
            err_count_o <= err_count_o + CNT_W'(1);
    end

endmodule

// File: tb/tb_hamming_codec.sv
// Directed bench for hamming_codec: hand-computed vectors, exhaustive single
// errors, counter clear/saturation (CNT_W=2 instance) and async reset.
module tb_hamming_codec;

    logic       clk = 1'b0;
    logic       rst;
    logic       enc_valid_i;
    logic [3:0] enc_data_i;
    logic       dec_valid_i;
    logic [6:0] dec_codeword_i;
    logic       err_count_clr_i;

    logic        enc_valid_o,  s_enc_valid_o;
    logic [6:0]  enc_codeword_o, s_enc_codeword_o;
    logic        dec_valid_o,  s_dec_valid_o;
    logic [3:0]  dec_data_o,   s_dec_data_o;
    logic [2:0]  dec_syndrome_o, s_dec_syndrome_o;
    logic        dec_err_o,    s_dec_err_o;
    logic [15:0] err_count_o;
    logic [1:0]  s_err_count_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Hand-computed codewords {d3,d2,d1,p4,d0,p2,p1} for nibbles 0..15.
    logic [6:0] cw_tbl [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                                7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

    always #5 clk = ~clk;

    hamming_codec dut (
        .clk(clk), .rst(rst),
        .enc_valid_i(enc_valid_i), .enc_data_i(enc_data_i),
        .enc_valid_o(enc_valid_o), .enc_codeword_o(enc_codeword_o),
        .dec_valid_i(dec_valid_i), .dec_codeword_i(dec_codeword_i),
        .dec_valid_o(dec_valid_o), .dec_data_o(dec_data_o),
        .dec_syndrome_o(dec_syndrome_o), .dec_err_o(dec_err_o),
        .err_count_clr_i(err_count_clr_i), .err_count_o(err_count_o)
    );

    hamming_codec #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .enc_valid_i(enc_valid_i), .enc_data_i(enc_data_i),
        .enc_valid_o(s_enc_valid_o), .enc_codeword_o(s_enc_codeword_o),
        .dec_valid_i(dec_valid_i), .dec_codeword_i(dec_codeword_i),
        .dec_valid_o(s_dec_valid_o), .dec_data_o(s_dec_data_o),
        .dec_syndrome_o(s_dec_syndrome_o), .dec_err_o(s_dec_err_o),
        .err_count_clr_i(err_count_clr_i), .err_count_o(s_err_count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dec(input string tag, input logic v, input logic [3:0] d,
                           input logic [2:0] s, input logic e);
        chk({tag, ".dec_valid"}, 32'(dec_valid_o), 32'(v));
        chk({tag, ".dec_data"},  32'(dec_data_o),  32'(d));
        chk({tag, ".dec_syn"},   32'(dec_syndrome_o), 32'(s));
        chk({tag, ".dec_err"},   32'(dec_err_o),   32'(e));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".enc_valid"}, 32'(enc_valid_o), 0);
        chk({tag, ".enc_cw"},    32'(enc_codeword_o), 0);
        chk_dec(tag, 1'b0, 4'h0, 3'h0, 1'b0);
        chk({tag, ".cnt"},     32'(err_count_o), 0);
        chk({tag, ".sat_cnt"}, 32'(s_err_count_o), 0);
        chk({tag, ".sat_dec_valid"}, 32'(s_dec_valid_o), 0);
    endtask

    initial begin
        logic [6:0] flip;
        rst = 1'b1; enc_valid_i = 1'b0; enc_data_i = '0;
        dec_valid_i = 1'b0; dec_codeword_i = '0; err_count_clr_i = 1'b0;
        #12;
        chk_all_zero("reset");
        rst = 1'b0;

        // Clean encode + decode of 1011.
        enc_valid_i = 1'b1; enc_data_i = 4'b1011;
        dec_valid_i = 1'b1; dec_codeword_i = 7'b1010101;
        step();
        chk("enc1.valid", 32'(enc_valid_o), 1);
        chk("enc1.cw",    32'(enc_codeword_o), 32'h55);
        chk_dec("clean", 1'b1, 4'b1011, 3'b000, 1'b0);
        chk("clean.cnt", 32'(err_count_o), 0);

        // Position 5 flipped.
        enc_valid_i = 1'b0; dec_codeword_i = 7'b1000101;
        step();
        chk("enc_idle.valid", 32'(enc_valid_o), 0);
        chk("enc_idle.hold",  32'(enc_codeword_o), 32'h55);
        chk_dec("pos5", 1'b1, 4'b1011, 3'b101, 1'b1);
        chk("pos5.cnt", 32'(err_count_o), 1);

        // Positions 3 and 5 flipped: miscorrection.
        dec_codeword_i = 7'b1000001;
        step();
        chk_dec("double", 1'b1, 4'b1100, 3'b110, 1'b1);
        chk("double.cnt", 32'(err_count_o), 2);

        // Idle decode: results hold, valid drops, counter unchanged.
        dec_valid_i = 1'b0; dec_codeword_i = 7'h7E;
        step();
        chk_dec("dec_idle", 1'b0, 4'b1100, 3'b110, 1'b1);
        chk("dec_idle.cnt", 32'(err_count_o), 2);

        // Exhaustive back-to-back: 16 nibbles x {clean, 7 single errors}.
        for (int d = 0; d < 16; d++) begin
            for (int e = 0; e < 8; e++) begin
                flip = (e == 0) ? 7'h00 : (7'h01 << (e - 1));
                enc_valid_i = 1'b1; enc_data_i = 4'(d);
                dec_valid_i = 1'b1; dec_codeword_i = cw_tbl[d] ^ flip;
                step();
                chk($sformatf("exh_d%0d_e%0d.enc_cw", d, e), 32'(enc_codeword_o), 32'(cw_tbl[d]));
                chk_dec($sformatf("exh_d%0d_e%0d", d, e), 1'b1, 4'(d), 3'(e), e != 0);
            end
        end
        enc_valid_i = 1'b0;
        chk("exh.cnt",     32'(err_count_o), 114);
        chk("exh.sat_cnt", 32'(s_err_count_o), 3);

        // Clear together with an erroring decode: clear wins.
        err_count_clr_i = 1'b1; dec_codeword_i = 7'h54;
        step();
        err_count_clr_i = 1'b0;
        chk_dec("clr", 1'b1, 4'b1011, 3'b001, 1'b1);
        chk("clr.cnt",     32'(err_count_o), 0);
        chk("clr.sat_cnt", 32'(s_err_count_o), 0);

        // Five erroring decodes: wide counter counts, 2-bit one saturates.
        dec_codeword_i = 7'h15;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("sat%0d.syn", i), 32'(s_dec_syndrome_o), 7);
            chk($sformatf("sat%0d.data", i), 32'(s_dec_data_o), 32'hB);
            chk($sformatf("sat%0d.cnt", i), 32'(err_count_o), 32'(i));
            chk($sformatf("sat%0d.sat_cnt", i), 32'(s_err_count_o), (i > 3) ? 3 : i);
        end

        // Mid-stream asynchronous reset.
        enc_valid_i = 1'b1; enc_data_i = 4'hF;
        step();
        chk("pre_rst.enc_cw", 32'(enc_codeword_o), 32'h7F);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        #3;
        rst = 1'b0; enc_valid_i = 1'b0; dec_valid_i = 1'b0;
        step();
        chk_all_zero("post_rst_idle");

        enc_valid_i = 1'b1; enc_data_i = 4'h6;
        dec_valid_i = 1'b1; dec_codeword_i = 7'h33 ^ 7'h08;
        step();
        chk("post_rst.enc_valid", 32'(enc_valid_o), 1);
        chk("post_rst.enc_cw",    32'(enc_codeword_o), 32'h33);
        chk_dec("post_rst", 1'b1, 4'h6, 3'b100, 1'b1);
        chk("post_rst.cnt", 32'(err_count_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
